event_arbiter: RTL and testbench

EVENT_ARBITER -- requirements
Module: event_arbiter

---
 rtl/event_arbiter.sv | 126 ++++++++++++
 tb/tb_event_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_arbiter.sv
// Event arbiter: double-flop synchronises width_p event pins, edge-detects them and offers
// pending events round-robin on a valid/ready port. EVENT_ARBITER_OVERFLOW_EN adds sticky overflow flags.
module event_arbiter #(
  parameter int unsigned  width_p       = 3,
  parameter bit           rising_edge_p = 1'b1,
  localparam int unsigned Idw           = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] d_i,
  output logic               valid_o,
  output logic [Idw-1:0]     id_o,
  input  logic               ready_i,
  output logic [width_p-1:0] overflow_o
);

  localparam int unsigned IdxW = Idw + 1;

  typedef enum logic {StIdle, StOffer} state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [width_p-1:0] pend_q, pend_d;
  logic [width_p-1:0] pulse, gnt_oh;
  logic [Idw-1:0]     ptr_q, ptr_d, id_q, id_d;
  logic [Idw-1:0]     winner;
  logic               found, grant;

  assign s1_d  = d_i;
  assign s2_d  = s1_q;
  assign pulse = rising_edge_p ? (s1_q & ~s2_q) : (~s1_q & s2_q);

  // Round-robin search over pending bits, starting at ptr_q and wrapping at width_p.
  always_comb begin : p_search
    logic [IdxW-1:0] idx;
    idx    = '0;
    winner = ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < width_p; i++) begin
      idx = {1'b0, ptr_q} + IdxW'(i);
      if (idx >= IdxW'(width_p)) begin
        idx = idx - IdxW'(width_p);
      end
      if (!found && pend_q[idx[Idw-1:0]]) begin
        found  = 1'b1;
        winner = idx[Idw-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    gnt_oh  = '0;
    grant   = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant   = 1'b1;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (ready_i) begin
          if (found) begin
            grant = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant) begin
      gnt_oh[winner] = 1'b1;
      id_d           = winner;
      ptr_d          = (winner == Idw'(width_p - 1)) ? '0 : winner + 1'b1;
    end
    // A new pulse on a channel being granted this cycle re-arms it rather than being lost.
    pend_d = (pend_q & ~gnt_oh) | pulse;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      state_q <= StIdle;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end

  assign valid_o = (state_q == StOffer);
  assign id_o    = id_q;

`ifdef EVENT_ARBITER_OVERFLOW_EN
  logic [width_p-1:0] ovf_q, ovf_d;

  // Drop happens when a channel pulses while already pending and not being granted.
  always_comb begin
    ovf_d = ovf_q | (pulse & pend_q & ~gnt_oh);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = '0;
`endif

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: vector table, hand-written corner sequences and
// randomized traffic compared against an event-level reference model.
module tb_event_arbiter;

  localparam int W  = 3;
  localparam int IW = 2;

  logic          clk      = 1'b0;
  logic          reset_ni = 1'b0;
  logic          ready_i  = 1'b0;
  logic [W-1:0]  d_i      = '0;
  logic [W-1:0]  d_f      = 3'b100;
  logic          valid_o, f_valid;
  logic [IW-1:0] id_o, f_id;
  logic [W-1:0]  overflow_o, f_ovf;

  always #5 clk = ~clk;

  event_arbiter #(.width_p(W), .rising_edge_p(1'b1)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .d_i        (d_i),
    .valid_o    (valid_o),
    .id_o       (id_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o)
  );

  event_arbiter #(.width_p(W), .rising_edge_p(1'b0)) dut_f (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .d_i        (d_f),
    .valid_o    (f_valid),
    .id_o       (f_id),
    .ready_i    (ready_i),
    .overflow_o (f_ovf)
  );

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int vcnt     = 0;
  int fcnt     = 0;
  int f_last   = -1;
  int v_last   = -1;

  // Reference model of the rising-edge instance: sampled input history, pending set,
  // current offer and round-robin start index.
  bit           m_pend[W];
  logic [W-1:0] m_ovf;
  bit           m_valid;
  int           m_id;
  int           m_ptr;
  logic [W-1:0] hist[$];

  function automatic void model_reset();
    for (int k = 0; k < W; k++) m_pend[k] = 1'b0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
    hist    = '{3'b000, 3'b000};
  endfunction

  function automatic void model_edge(input logic [W-1:0] d, input logic rdy);
    logic [W-1:0] newest, older;
    bit           old_pend[W];
    int           win, c;
    bit           granted;
    newest  = hist[hist.size()-1];
    older   = hist[hist.size()-2];
    for (int k = 0; k < W; k++) old_pend[k] = m_pend[k];
    win     = -1;
    granted = 1'b0;
    if (!m_valid || rdy) begin
      for (int j = 0; j < W; j++) begin
        c = (m_ptr + j) % W;
        if (win < 0 && old_pend[c]) win = c;
      end
      if (win >= 0) begin
        granted      = 1'b1;
        m_valid      = 1'b1;
        m_id         = win;
        m_ptr        = (win + 1) % W;
        m_pend[win]  = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int k = 0; k < W; k++) begin
      if (newest[k] && !older[k]) begin
        if (old_pend[k] && !(granted && win == k)) m_ovf[k] = 1'b1;
        m_pend[k] = 1'b1;
      end
    end
    hist.push_back(d);
    if (hist.size() > 2) void'(hist.pop_front());
  endfunction

  function automatic logic [W-1:0] exp_ovf();
    logic [W-1:0] r;
    r = '0;
`ifdef EVENT_ARBITER_OVERFLOW_EN
    r = m_ovf;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called half a cycle away from the edge: drive, clock once, compare with the model.
  task automatic step(input logic [W-1:0] d, input logic rdy);
    d_i     = d;
    ready_i = rdy;
    if (valid_o && rdy) xfer_cnt++;
    @(posedge clk);
    model_edge(d, rdy);
    #1;
    check("valid", valid_o, m_valid);
    if (m_valid) check("id", id_o, m_id);
    check("overflow", overflow_o, exp_ovf());
    if (valid_o) begin
      vcnt++;
      v_last = id_o;
    end
    if (f_valid) begin
      fcnt++;
      f_last = f_id;
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    d_i      = '0;
    ready_i  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
  endtask

  task automatic pulse0_stalled();
    step(3'b001, 1'b0);
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
  endtask

  typedef struct packed {
    bit            rst;
    logic [W-1:0]  d;
    bit            rdy;
    bit            ev;
    logic [IW-1:0] eid;
  } vec_t;

  vec_t vecs[$];

  logic [W-1:0] exp_sticky;
  logic [W-1:0] rd;

  initial begin
    // Single event on channel 1
    vecs.push_back('{1'b1, 3'b010, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b010, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b010, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 3'b010, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 2'd0});
    // Simultaneous events, then a check that the pointer wrapped back to 0
    vecs.push_back('{1'b1, 3'b111, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{1'b0, 3'b111, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b000, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b101, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b101, 1'b1, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b101, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1'b0, 3'b101, 1'b1, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b101, 1'b1, 1'b0, 2'd0});
    // Backpressure on channel 2: five stalled cycles, transfer on the sixth
    vecs.push_back('{1'b1, 3'b100, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b0, 2'd0});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b100, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{1'b0, 3'b100, 1'b1, 1'b0, 2'd0});

    exp_sticky = '0;
`ifdef EVENT_ARBITER_OVERFLOW_EN
    exp_sticky = 3'b001;
`endif

    // Values while reset is held
    model_reset();
    #2;
    check("reset_valid", valid_o, 1'b0);
    check("reset_id", id_o, 2'd0);
    check("reset_overflow", overflow_o, 3'b000);
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].ev);
      if (vecs[i].ev) check($sformatf("vec%0d_id", i), id_o, vecs[i].eid);
    end

    // Overflow: third pulse on channel 0 while one is offered and one pending
    do_reset();
    pulse0_stalled();
    pulse0_stalled();
    pulse0_stalled();
    $display("note: model overflow flags %b", m_ovf);
    check("ovf_sticky", overflow_o, exp_sticky);
    check("ovf_offer_valid", valid_o, 1'b1);
    check("ovf_offer_id", id_o, 2'd0);
    xfer_cnt = 0;
    repeat (4) step(3'b000, 1'b1);
    check("ovf_transfers", xfer_cnt, 2);
    check("ovf_still_sticky", overflow_o, exp_sticky);

    // Asynchronous reset in the middle of an offer
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    check("pre_reset_valid", valid_o, 1'b1);
    check("pre_reset_id", id_o, 2'd1);
    #3;
    reset_ni = 1'b0;
    model_reset();
    #1;
    check("async_valid", valid_o, 1'b0);
    check("async_id", id_o, 2'd0);
    check("async_overflow", overflow_o, 3'b000);
    d_i = '0;
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    vcnt = 0;
    repeat (8) step(3'b000, 1'b1);
    check("post_reset_events", vcnt, 0);

    // Input already high when reset releases yields exactly one event
    reset_ni = 1'b0;
    d_i      = 3'b001;
    model_reset();
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    vcnt = 0;
    repeat (6) step(3'b001, 1'b1);
    check("high_at_reset_events", vcnt, 1);
    check("high_at_reset_id", v_last, 0);

    // Falling-edge instance: 1->0 on channel 2 is an event, 0->1 is not
    do_reset();
    fcnt = 0;
    repeat (3) step(3'b000, 1'b1);
    check("fall_idle_events", fcnt, 0);
    d_f = 3'b000;
    repeat (6) step(3'b000, 1'b1);
    check("fall_events", fcnt, 1);
    check("fall_id", f_last, 2);
    check("fall_overflow", f_ovf, 3'b000);
    d_f  = 3'b100;
    fcnt = 0;
    repeat (6) step(3'b000, 1'b1);
    check("rise_in_fall_mode", fcnt, 0);

    // Randomized traffic against the model
    do_reset();
    rd = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < W; k++) begin
        if ($urandom_range(3) == 0) rd[k] = ~rd[k];
      end
      step(rd, ($urandom_range(2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
